// File: rtl/wave_loop_fifo_pkg.sv
// Shared types for the RFSoC waveform loop FIFO: FSM state encoding and mux_sel values.
package rfsoc_config;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_LOOP  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic MUX_LOAD = 1'b0;
  localparam logic MUX_LOOP = 1'b1;

endpackage

// File: rtl/wave_loop_fifo_if.sv
// Load and playback streams of the waveform loop FIFO.
// Handshake: a word transfers on the rising clk edge where tvalid && tready; tvalid never depends on tready.
interface wave_loop_fifo_if #(
  parameter int WIDTH = 256
);
  logic [WIDTH-1:0] s_load_tdata;
  logic             s_load_tvalid;
  logic             s_load_tready;
  logic [WIDTH-1:0] m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;

  modport master (
    output s_load_tdata, s_load_tvalid, m_axis_tready,
    input  s_load_tready, m_axis_tdata, m_axis_tvalid
  );

  modport slave (
    input  s_load_tdata, s_load_tvalid, m_axis_tready,
    output s_load_tready, m_axis_tdata, m_axis_tvalid
  );
endinterface

// File: rtl/wave_loop_fifo_ram.sv
// wave_ram: simple dual-port RAM, WIDTH x DEPTH, with a synchronous read register that can be cleared.
module wave_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  input  logic             rd_clr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register doubles as the FIFO's output word, so it obeys reset/flush.
  always_ff @(posedge clk) begin
    if (rd_clr)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/wave_loop_fifo.sv
// Waveform FIFO that loads words from the PS, then replays them in a loop to the DAC controller.
// Optional error flags are built only when WAVE_LOOP_FIFO_ERR_EN is defined.
module wave_loop_fifo
  import rfsoc_config::*;
#(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  wave_loop_fifo_if.slave          bus,
  input  logic                     mux_sel,
  input  logic                     loopback_valid,
  input  logic                     clear,
  output logic [$clog2(DEPTH)+1:0] level,
  output logic [1:0]               err_flags,
  output state_t                   dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 2;

  state_t           state;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      ram_count;
  logic             out_valid;
  logic [WIDTH-1:0] rdata;
  logic             load_fire, pop, wb, we, re, flush;
  logic [WIDTH-1:0] wdata;

  assign flush     = !rst || clear;
  assign load_fire = bus.s_load_tvalid && bus.s_load_tready;
  assign pop       = out_valid && bus.m_axis_tready;
  assign wb        = pop && (state == ST_LOOP);
  assign we        = load_fire || wb;
  assign wdata     = wb ? rdata : bus.s_load_tdata;
  // Refill whenever the output word is absent or leaving and RAM has something to give.
  assign re        = (ram_count != '0) && (!out_valid || pop);

  assign level             = LW'(ram_count) + LW'(out_valid);
  assign bus.s_load_tready = rst && (state == ST_LOAD) && (level < LW'(DEPTH));
  assign bus.m_axis_tvalid = out_valid;
  assign bus.m_axis_tdata  = rdata;
  assign dbg_state         = state;

  wave_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_ram (
    .clk    (clk),
    .we     (we),
    .waddr  (wr_ptr),
    .wdata  (wdata),
    .re     (re),
    .raddr  (rd_ptr),
    .rd_clr (flush),
    .rdata  (rdata)
  );

  always_ff @(posedge clk) begin
    if (flush) begin
      state     <= rst ? ST_FLUSH : ST_LOAD;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      out_valid <= 1'b0;
    end else begin
      // Mode changes wait for the DAC controller to finish its current playback.
      case (state)
        ST_LOAD:  if (mux_sel == MUX_LOOP && !loopback_valid) state <= ST_LOOP;
        ST_LOOP:  if (mux_sel == MUX_LOAD && !loopback_valid) state <= ST_LOAD;
        ST_FLUSH: state <= (mux_sel == MUX_LOOP) ? ST_LOOP : ST_LOAD;
        default:  state <= ST_LOAD;
      endcase
      if (we) wr_ptr <= wr_ptr + AW'(1);
      if (re) rd_ptr <= rd_ptr + AW'(1);
      ram_count <= ram_count + (AW+1)'(we) - (AW+1)'(re);
      if (re)       out_valid <= 1'b1;
      else if (pop) out_valid <= 1'b0;
    end
  end

`ifdef WAVE_LOOP_FIFO_ERR_EN
  logic [1:0] err_q;

  always_ff @(posedge clk) begin
    if (flush) begin
      err_q <= 2'b00;
    end else begin
      if (loopback_valid && bus.m_axis_tready && !out_valid) err_q[0] <= 1'b1;
      if (bus.s_load_tvalid && state != ST_LOAD)             err_q[1] <= 1'b1;
    end
  end

  assign err_flags = err_q;
`else
  assign err_flags = 2'b00;
`endif
endmodule

// File: tb/tb_wave_loop_fifo.sv
// Self-checking bench for wave_loop_fifo: scoreboard of expected playback words plus directed checks.
module tb_wave_loop_fifo;
  import rfsoc_config::*;

  localparam int DEPTH = 1024;
  localparam int WIDTH = 256;
  localparam int LW    = $clog2(DEPTH) + 2;

`ifdef WAVE_LOOP_FIFO_ERR_EN
  localparam logic [1:0] EXP_UNDERFLOW = 2'b01;
  localparam logic [1:0] EXP_BLOCKED   = 2'b10;
`else
  localparam logic [1:0] EXP_UNDERFLOW = 2'b00;
  localparam logic [1:0] EXP_BLOCKED   = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mux_sel = 1'b0;
  logic          loopback_valid = 1'b0;
  logic          clear = 1'b0;
  logic [LW-1:0] level;
  logic [1:0]    err_flags;
  state_t        dbg_state;

  wave_loop_fifo_if #(.WIDTH(WIDTH)) bus ();

  wave_loop_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .mux_sel        (mux_sel),
    .loopback_valid (loopback_valid),
    .clear          (clear),
    .level          (level),
    .err_flags      (err_flags),
    .dbg_state      (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int             checks = 0;
  int             failures = 0;
  logic [WIDTH-1:0] exp_q[$];
  state_t         m_state = ST_LOAD;

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] w;
    for (int i = 0; i < WIDTH / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // One clock cycle: score this cycle's handshakes, advance the mode model, land #1 after the edge.
  task automatic step();
    logic             pop_hs, load_hs;
    logic [WIDTH-1:0] w;
    #1;
    pop_hs  = bus.m_axis_tvalid && bus.m_axis_tready;
    load_hs = bus.s_load_tvalid && bus.s_load_tready;
    if (!rst || clear) begin
      exp_q.delete();
    end else begin
      if (pop_hs) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_empty_model actual=%0h required=no_pop", bus.m_axis_tdata);
        end else begin
          w = exp_q.pop_front();
          check_eq("pop_data", bus.m_axis_tdata, w);
          if (m_state == ST_LOOP) exp_q.push_back(w);
        end
      end
      if (load_hs) exp_q.push_back(bus.s_load_tdata);
    end
    if (!rst)       m_state = ST_LOAD;
    else if (clear) m_state = ST_FLUSH;
    else begin
      case (m_state)
        ST_LOAD:  if (mux_sel && !loopback_valid) m_state = ST_LOOP;
        ST_LOOP:  if (!mux_sel && !loopback_valid) m_state = ST_LOAD;
        default:  m_state = mux_sel ? ST_LOOP : ST_LOAD;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input int n);
    for (int i = 0; i < n; i++) begin
      bus.s_load_tvalid = 1'b1;
      bus.s_load_tdata  = rand_word();
      step();
    end
    bus.s_load_tvalid = 1'b0;
  endtask

  initial begin
    int n;
    bus.s_load_tdata  = '0;
    bus.s_load_tvalid = 1'b0;
    bus.m_axis_tready = 1'b0;

    // reset state
    step();
    step();
    check_eq("rst_tready", WIDTH'(bus.s_load_tready), '0);
    check_eq("rst_tvalid", WIDTH'(bus.m_axis_tvalid), '0);
    check_eq("rst_level", WIDTH'(level), '0);
    check_eq("rst_err", WIDTH'(err_flags), '0);
    check_eq("rst_state", WIDTH'(dbg_state), WIDTH'(ST_LOAD));
    rst = 1'b1;
    #1;
    check_eq("rel_tready", WIDTH'(bus.s_load_tready), WIDTH'(1));

    // FWFT latency: first word visible two cycles after the first write
    bus.s_load_tvalid = 1'b1;
    bus.s_load_tdata  = rand_word();
    step();
    check_eq("fwft_tvalid_1", WIDTH'(bus.m_axis_tvalid), '0);
    bus.s_load_tdata = rand_word();
    step();
    check_eq("fwft_tvalid_2", WIDTH'(bus.m_axis_tvalid), WIDTH'(1));
    check_eq("fwft_tdata", bus.m_axis_tdata, exp_q[0]);
    load_words(2);
    step();
    check_eq("load4_level", WIDTH'(level), WIDTH'(4));
    check_eq("load4_level_model", WIDTH'(level), WIDTH'(exp_q.size()));

    // loop playback: 12 pops of A..D, no gaps, level constant
    mux_sel = MUX_LOOP;
    step();
    check_eq("to_loop", WIDTH'(dbg_state), WIDTH'(ST_LOOP));
    loopback_valid    = 1'b1;
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check_eq("loop_no_gap", WIDTH'(bus.m_axis_tvalid), WIDTH'(1));
      step();
      check_eq("loop_level", WIDTH'(level), WIDTH'(4));
    end

    // mode change deferred while playback is active
    bus.m_axis_tready = 1'b0;
    mux_sel = MUX_LOAD;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("hold_loop", WIDTH'(dbg_state), WIDTH'(ST_LOOP));
    end
    loopback_valid = 1'b0;
    step();
    check_eq("back_to_load", WIDTH'(dbg_state), WIDTH'(ST_LOAD));

    // flush, then fill to DEPTH
    clear = 1'b1;
    step();
    check_eq("flush_state", WIDTH'(dbg_state), WIDTH'(ST_FLUSH));
    check_eq("flush_level", WIDTH'(level), '0);
    check_eq("flush_tvalid", WIDTH'(bus.m_axis_tvalid), '0);
    check_eq("flush_tready", WIDTH'(bus.s_load_tready), '0);
    clear = 1'b0;
    step();
    check_eq("flush_exit", WIDTH'(dbg_state), WIDTH'(ST_LOAD));
    n = 0;
    bus.s_load_tvalid = 1'b1;
    while (bus.s_load_tready && n < DEPTH + 64) begin
      bus.s_load_tdata = rand_word();
      step();
      n++;
    end
    bus.s_load_tvalid = 1'b0;
    check_eq("fill_cycles", WIDTH'(n), WIDTH'(DEPTH));
    check_eq("full_level", WIDTH'(level), WIDTH'(DEPTH));
    check_eq("full_tready", WIDTH'(bus.s_load_tready), '0);

    // loop at full: order preserved, level constant
    mux_sel = MUX_LOOP;
    step();
    loopback_valid    = 1'b1;
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < DEPTH + 40; i++) begin
      step();
      check_eq("full_loop_level", WIDTH'(level), WIDTH'(DEPTH));
    end
    bus.m_axis_tready = 1'b0;
    step();

    // load attempt outside ST_LOAD
    bus.s_load_tvalid = 1'b1;
    bus.s_load_tdata  = rand_word();
    step();
    bus.s_load_tvalid = 1'b0;
    check_eq("load_blocked", WIDTH'(err_flags), WIDTH'(EXP_BLOCKED));

    // underflow on empty FIFO, then clear
    clear = 1'b1;
    loopback_valid = 1'b0;
    mux_sel = MUX_LOAD;
    step();
    check_eq("clr_err", WIDTH'(err_flags), '0);
    clear = 1'b0;
    step();
    loopback_valid    = 1'b1;
    bus.m_axis_tready = 1'b1;
    step();
    check_eq("underflow", WIDTH'(err_flags), WIDTH'(EXP_UNDERFLOW));
    clear = 1'b1;
    step();
    check_eq("uf_clr_err", WIDTH'(err_flags), '0);
    check_eq("uf_clr_level", WIDTH'(level), '0);
    clear = 1'b0;
    loopback_valid    = 1'b0;
    bus.m_axis_tready = 1'b0;
    step();

    // reset pulse mid-loop
    load_words(4);
    mux_sel = MUX_LOOP;
    step();
    loopback_valid    = 1'b1;
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b0;
    step();
    check_eq("mid_rst_tvalid", WIDTH'(bus.m_axis_tvalid), '0);
    check_eq("mid_rst_tready", WIDTH'(bus.s_load_tready), '0);
    check_eq("mid_rst_level", WIDTH'(level), '0);
    check_eq("mid_rst_err", WIDTH'(err_flags), '0);
    check_eq("mid_rst_tdata", bus.m_axis_tdata, '0);
    check_eq("mid_rst_state", WIDTH'(dbg_state), WIDTH'(ST_LOAD));
    rst = 1'b1;
    mux_sel = MUX_LOAD;
    loopback_valid    = 1'b0;
    bus.m_axis_tready = 1'b0;
    #1;
    check_eq("post_rst_tready", WIDTH'(bus.s_load_tready), WIDTH'(1));

    // final: reload and drain in load mode
    load_words(3);
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check_eq("drain_level", WIDTH'(level), '0);
    check_eq("drain_model", WIDTH'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
